// File: rtl/control_edicion_botones.sv
// rtl/control_edicion_botones.sv - button-driven field selection and step requests for counter setup
// Purpose: synchronizes and debounces five raw buttons, runs an IDLE/EDIT mode
// FSM that selects one of NUM_FIELDS fields and issues one-cycle step pulses.
// Ports:
//   clk                  sole clock, rising edge
//   reset                synchronous, active-high
//   btn_prog             toggles edit mode
//   btn_left, btn_right  move field selection (wrapping)
//   btn_up, btn_down     increment / decrement requests
//   en_count[3:0]        0 = none, 1..NUM_FIELDS = selected field
//   enUP, enDOWN         one-cycle increment / decrement pulses
//   prog_mode            high while in edit mode
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held up/down button.
module control_edicion_botones #(
    parameter int DEB_CYCLES    = 1000000,
    parameter int NUM_FIELDS    = 3,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       prog_mode
);
    localparam int B_PROG  = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [3:0]    LAST_FIELD = 4'(NUM_FIELDS);

    typedef enum logic {IDLE, EDIT} state_t;

    logic [4:0]    raw;
    logic [4:0]    meta_q, sync_q, lvl_q, lvl_prev_q, armed_q;
    logic [1:0]    fill_q;
    logic [DW-1:0] dcnt_q [5];
    logic [4:0]    ev;

    assign raw = {btn_down, btn_up, btn_right, btn_left, btn_prog};

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            armed_q    <= '0;
            fill_q     <= '0;
            for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            lvl_prev_q <= lvl_q;
            fill_q     <= {fill_q[0], 1'b1};
            // A button arms only after a released sample is seen once the
            // synchronizer holds real data, so one held through reset stays silent.
            armed_q    <= armed_q | ({5{fill_q[1]}} & ~sync_q);
            for (int i = 0; i < 5; i++) begin
                if (sync_q[i] == lvl_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DEB_LAST) begin
                    lvl_q[i]  <= sync_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign ev = lvl_q & ~lvl_prev_q & armed_q;

    state_t     state_q, state_d;
    logic [3:0] field_q, field_d;
    logic       up_q, up_d, dn_q, dn_d;
    logic       field_chg, rep_up, rep_dn, up_req, dn_req;

    assign field_chg = (state_q == EDIT) && !ev[B_PROG] && (ev[B_LEFT] ^ ev[B_RIGHT]);

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          ron_q, ron_d, rdir_q, rdir_d, rper_q, rper_d;
    logic          hold_ok, held, rfire;

    assign hold_ok = (state_q == EDIT) && !ev[B_PROG] && !(lvl_q[B_UP] && lvl_q[B_DOWN]);
    assign held    = rdir_q ? lvl_q[B_DOWN] : lvl_q[B_UP];

    // rcnt counts cycles since the press event (or the last repeat pulse);
    // rper selects the initial delay or the steady repeat period.
    always_comb begin
        rcnt_d = rcnt_q;
        ron_d  = ron_q;
        rdir_d = rdir_q;
        rper_d = rper_q;
        rfire  = 1'b0;
        if (hold_ok && (ev[B_UP] || ev[B_DOWN])) begin
            ron_d  = 1'b1;
            rdir_d = ev[B_DOWN];
            rcnt_d = RW'(1);
            rper_d = 1'b0;
        end else if (hold_ok && ron_q && held && !field_chg) begin
            if (rcnt_q == (rper_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
                rfire  = 1'b1;
                rcnt_d = RW'(1);
                rper_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end else begin
            ron_d  = 1'b0;
            rcnt_d = '0;
            rper_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q <= '0;
            ron_q  <= 1'b0;
            rdir_q <= 1'b0;
            rper_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            ron_q  <= ron_d;
            rdir_q <= rdir_d;
            rper_q <= rper_d;
        end
    end

    assign rep_up = rfire && !rdir_q;
    assign rep_dn = rfire && rdir_q;
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign up_req = ev[B_UP] | rep_up;
    assign dn_req = ev[B_DOWN] | rep_dn;

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        case (state_q)
            IDLE: begin
                field_d = '0;
                if (ev[B_PROG]) begin
                    state_d = EDIT;
                    field_d = 4'd1;
                end
            end
            EDIT: begin
                if (ev[B_PROG]) begin
                    state_d = IDLE;
                    field_d = '0;
                end else begin
                    if (ev[B_RIGHT] && !ev[B_LEFT])
                        field_d = (field_q >= LAST_FIELD) ? 4'd1 : field_q + 4'd1;
                    else if (ev[B_LEFT] && !ev[B_RIGHT])
                        field_d = (field_q <= 4'd1) ? LAST_FIELD : field_q - 4'd1;
                    // Either debounced level of the opposite button blocks the pulse.
                    up_d = up_req && !dn_req && !lvl_q[B_DOWN];
                    dn_d = dn_req && !up_req && !lvl_q[B_UP];
                end
            end
            default: begin
                state_d = IDLE;
                field_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            field_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign en_count  = field_q;
    assign enUP      = up_q;
    assign enDOWN    = dn_q;
    assign prog_mode = (state_q == EDIT);
endmodule

// File: tb/tb_control_edicion_botones.sv
// tb/tb_control_edicion_botones.sv - self-checking bench for control_edicion_botones
module tb_control_edicion_botones;
    localparam int DEB = 4;
    localparam int NF  = 3;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btns = '0;
    logic [3:0] en_count;
    logic       enUP, enDOWN, prog_mode;

    int total = 0;
    int bad = 0;
    int up_cnt = 0, dn_cnt = 0, up_long = 0, dn_long = 0, both_hi = 0;
    int cyc = 0;
    logic up_prev = 1'b0, dn_prev = 1'b0;
    int up_times[$];

    control_edicion_botones #(
        .DEB_CYCLES(DEB), .NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_prog(btns[0]), .btn_left(btns[1]), .btn_right(btns[2]),
        .btn_up(btns[3]), .btn_down(btns[4]),
        .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN), .prog_mode(prog_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enUP) begin
            up_cnt++;
            up_times.push_back(cyc);
            if (up_prev) up_long++;
        end
        if (enDOWN) begin
            dn_cnt++;
            if (dn_prev) dn_long++;
        end
        if (enUP && enDOWN) both_hi++;
        up_prev = enUP;
        dn_prev = enDOWN;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b, input int hold, input int gap);
        btns[b] = 1'b1;
        tick(hold);
        btns[b] = 1'b0;
        tick(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btns  = '0;
        tick(2);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++; if (en_count !== 4'd0) begin bad++; $display("FAIL reset_en_count: got %0d want 0", en_count); end
        total++; if (prog_mode !== 1'b0) begin bad++; $display("FAIL reset_prog_mode: got %b want 0", prog_mode); end
        total++; if (enUP !== 1'b0) begin bad++; $display("FAIL reset_enUP: got %b want 0", enUP); end
        total++; if (enDOWN !== 1'b0) begin bad++; $display("FAIL reset_enDOWN: got %b want 0", enDOWN); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_mode_wrap();
        int exp_seq[4] = '{2, 3, 1, 3};
        do_reset();
        press(0, 10, 10);
        total++; if (prog_mode !== 1'b1) begin bad++; $display("FAIL wrap_enter_mode: got %b want 1", prog_mode); end
        total++; if (en_count !== 4'd1) begin bad++; $display("FAIL wrap_enter_field: got %0d want 1", en_count); end
        for (int i = 0; i < 4; i++) begin
            press((i < 3) ? 2 : 1, 10, 10);
            total++;
            if (en_count !== 4'(exp_seq[i])) begin
                bad++; $display("FAIL wrap_step%0d: got %0d want %0d", i, en_count, exp_seq[i]);
            end
        end
        press(0, 10, 10);
        total++; if (en_count !== 4'd0) begin bad++; $display("FAIL wrap_exit_field: got %0d want 0", en_count); end
        total++; if (prog_mode !== 1'b0) begin bad++; $display("FAIL wrap_exit_mode: got %b want 0", prog_mode); end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        press(0, 10, 10);
        base = up_cnt;
        for (int i = 0; i < 20; i++) begin
            btns[3] = 1'b1; tick(2);
            btns[3] = 1'b0; tick(2);
        end
        tick(10);
        total++; if (up_cnt - base !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", up_cnt - base); end
    endtask

    task automatic test_single_step();
        int bd, bu, bl;
        do_reset();
        press(0, 10, 10);
        press(2, 10, 10);
        bd = dn_cnt; bu = up_cnt; bl = dn_long;
        press(4, 10, 12);
        total++; if (dn_cnt - bd !== 1) begin bad++; $display("FAIL step_down_count: got %0d want 1", dn_cnt - bd); end
        total++; if (dn_long - bl !== 0) begin bad++; $display("FAIL step_down_width: got %0d long cycles want 0", dn_long - bl); end
        total++; if (up_cnt - bu !== 0) begin bad++; $display("FAIL step_no_up: got %0d want 0", up_cnt - bu); end
        total++; if (en_count !== 4'd2) begin bad++; $display("FAIL step_field: got %0d want 2", en_count); end
        press(0, 10, 10);
        bd = dn_cnt;
        press(4, 10, 12);
        total++; if (dn_cnt - bd !== 0) begin bad++; $display("FAIL step_idle_down: got %0d want 0", dn_cnt - bd); end
    endtask

    task automatic test_conflict();
        int bu, bd;
        do_reset();
        press(0, 10, 10);
        press(2, 10, 10);
        bu = up_cnt; bd = dn_cnt;
        btns[3] = 1'b1; btns[4] = 1'b1;
        tick(12);
        btns[3] = 1'b0; btns[4] = 1'b0;
        tick(12);
        total++; if (up_cnt - bu !== 0) begin bad++; $display("FAIL conflict_up: got %0d want 0", up_cnt - bu); end
        total++; if (dn_cnt - bd !== 0) begin bad++; $display("FAIL conflict_down: got %0d want 0", dn_cnt - bd); end
        btns[1] = 1'b1; btns[2] = 1'b1;
        tick(12);
        btns[1] = 1'b0; btns[2] = 1'b0;
        tick(12);
        total++; if (en_count !== 4'd2) begin bad++; $display("FAIL conflict_left_right: got %0d want 2", en_count); end
    endtask

    // Reference model: edit flag plus a field number in 1..NF, updated by
    // modular arithmetic per completed button press.
    task automatic test_random();
        int mode = 0, field = 0, exp_up = 0, exp_dn = 0, bu, bd, b;
        do_reset();
        bu = up_cnt; bd = dn_cnt;
        for (int it = 0; it < 30; it++) begin
            b = $urandom_range(0, 4);
            press(b, 10 + $urandom_range(0, 5), 10 + $urandom_range(0, 5));
            if (b == 0) begin
                mode  = 1 - mode;
                field = mode;
            end else if (mode == 1) begin
                case (b)
                    1: field = (field == 1) ? NF : field - 1;
                    2: field = (field % NF) + 1;
                    3: exp_up++;
                    default: exp_dn++;
                endcase
            end
            total++; if (en_count !== 4'(field)) begin bad++; $display("FAIL rand_field it%0d btn%0d: got %0d want %0d", it, b, en_count, field); end
            total++; if (prog_mode !== 1'(mode)) begin bad++; $display("FAIL rand_mode it%0d btn%0d: got %b want %0d", it, b, prog_mode, mode); end
        end
        total++; if (up_cnt - bu !== exp_up) begin bad++; $display("FAIL rand_up_total: got %0d want %0d", up_cnt - bu, exp_up); end
        total++; if (dn_cnt - bd !== exp_dn) begin bad++; $display("FAIL rand_down_total: got %0d want %0d", dn_cnt - bd, exp_dn); end
    endtask

    task automatic test_auto_repeat();
        int base, n;
        bit seen;
        int offs[6] = '{0, RD, RD + RP, RD + 2 * RP, RD + 3 * RP, RD + 4 * RP};
        do_reset();
        press(0, 10, 10);
        base = up_times.size();
        btns[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1);
            if (enUP) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL repeat_first_pulse: got none within 30 cycles want one"); end
        tick(50);
        btns[3] = 1'b0;
        tick(20);
        n = up_times.size() - base;
`ifdef AUTO_REPEAT_EN
        total++; if (n !== 6) begin bad++; $display("FAIL repeat_count: got %0d want 6", n); end
        if (n == 6) begin
            for (int k = 1; k < 6; k++) begin
                total++;
                if (up_times[base + k] - up_times[base] !== offs[k]) begin
                    bad++; $display("FAIL repeat_offset%0d: got %0d want %0d", k, up_times[base + k] - up_times[base], offs[k]);
                end
            end
        end
`else
        total++; if (n !== 1) begin bad++; $display("FAIL repeat_single: got %0d want 1 (offs %0d)", n, offs[1]); end
`endif
    endtask

    task automatic test_reset_mid_hold();
        int base;
        do_reset();
        press(0, 10, 10);
        base = up_cnt;
        btns[3] = 1'b1;
        tick(12);
        total++; if (up_cnt - base !== 1) begin bad++; $display("FAIL hold_pre_reset: got %0d want 1", up_cnt - base); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++; if (en_count !== 4'd0) begin bad++; $display("FAIL hold_reset_field: got %0d want 0", en_count); end
        total++; if (prog_mode !== 1'b0) begin bad++; $display("FAIL hold_reset_mode: got %b want 0", prog_mode); end
        tick(15);
        press(0, 10, 10);
        base = up_cnt;
        tick(30);
        total++; if (up_cnt - base !== 0) begin bad++; $display("FAIL hold_no_refire: got %0d want 0", up_cnt - base); end
        btns[3] = 1'b0;
        tick(12);
        press(3, 10, 12);
        total++; if (up_cnt - base !== 1) begin bad++; $display("FAIL hold_repress: got %0d want 1", up_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_mode_wrap();
        test_glitch();
        test_single_step();
        test_conflict();
        test_random();
        test_auto_repeat();
        test_reset_mid_hold();
        total++; if (both_hi !== 0) begin bad++; $display("FAIL both_pulses: got %0d cycles want 0", both_hi); end
        total++; if (up_long + dn_long !== 0) begin bad++; $display("FAIL pulse_width: got %0d long cycles want 0", up_long + dn_long); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
